// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: widths, default geometry and refill FSM state type for the instruction cache
package inst_cache_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int RAM_W = 8;
  localparam int ICACHE_INDEX_BITS = 7;
  localparam logic [ADDR_W-1:0] ADDR_FREE = '0;
  localparam logic [INST_W-1:0] DATA_FREE = '0;
  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;
endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetch side (instEn/instAddr/misTaken -> hit/cacheInst/memInstOutEn/memInst) and byte RAM side (ramReq/ramAddr -> ramGnt/ramData); slave = cache
interface inst_cache_if;
  import inst_cache_pkg::*;
  logic instEn;
  logic [ADDR_W-1:0] instAddr;
  logic misTaken;
  logic hit;
  logic [INST_W-1:0] cacheInst;
  logic memInstOutEn;
  logic [INST_W-1:0] memInst;
  logic ramReq;
  logic [ADDR_W-1:0] ramAddr;
  logic ramGnt;
  logic [RAM_W-1:0] ramData;
  modport slave (
    input instEn, instAddr, misTaken, ramGnt, ramData,
    output hit, cacheInst, memInstOutEn, memInst, ramReq, ramAddr
  );
  modport master (
    output instEn, instAddr, misTaken, ramGnt, ramData,
    input hit, cacheInst, memInstOutEn, memInst, ramReq, ramAddr
  );
endinterface

// File: rtl/inst_cache_store.sv
// inst_cache_store: direct-mapped valid/tag/data arrays; ports clk, rst (low clears valid), comb read ridx/rtag -> rhit/rdata, sync write we/widx/wtag/wdata
module inst_cache_store import inst_cache_pkg::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [INDEX_BITS-1:0] ridx,
  input logic [INDEX_BITS-1:0] widx,
  input logic [TAG_W-1:0] rtag,
  input logic [TAG_W-1:0] wtag,
  input logic [INST_W-1:0] wdata,
  output logic rhit,
  output logic [INST_W-1:0] rdata
);
  logic [(1<<INDEX_BITS)-1:0] valid;
  logic [TAG_W-1:0] tags [1<<INDEX_BITS];
  logic [INST_W-1:0] data [1<<INDEX_BITS];
  assign rhit = valid[ridx] & (tags[ridx] == rtag);
  assign rdata = data[ridx];
  always_ff @(posedge clk)
    if (!rst) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: fetch-side instruction cache; ports clk, rst (sync active-low), rdy (global hold), bus (inst_cache_if.slave) with same-cycle hit and byte-serial miss refill
module inst_cache import inst_cache_pkg::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  inst_cache_if.slave bus
);
  state_t state;
  logic [ADDR_W-3:0] req_word;
  logic [2:0] issued;
  logic [1:0] rcv;
  logic pending, line_hit, fill, grant, unused_lsb;
  logic [23:0] word;
  logic [INST_W-1:0] fill_word;
  assign unused_lsb = ^bus.instAddr[1:0];
  assign grant = bus.ramReq & bus.ramGnt;
  // bytes 0..2 shift in from the top, byte 3 is taken straight off the bus
  assign fill_word = {bus.ramData, word};
  assign fill = rst & rdy & (state == REFILL) & ~bus.misTaken & pending & (rcv == 2'd3);
  assign bus.hit = bus.instEn & line_hit;
  assign bus.ramAddr = {req_word, issued[1:0]};
  inst_cache_store #(.INDEX_BITS(INDEX_BITS)) store (
    .clk(clk),
    .rst(rst),
    .we(fill),
    .ridx(bus.instAddr[INDEX_BITS+1:2]),
    .widx(req_word[INDEX_BITS-1:0]),
    .rtag(bus.instAddr[ADDR_W-1:INDEX_BITS+2]),
    .wtag(req_word[ADDR_W-3:INDEX_BITS]),
    .wdata(fill_word),
    .rhit(line_hit),
    .rdata(bus.cacheInst)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      bus.memInstOutEn <= 1'b0;
      bus.ramReq <= 1'b0;
      bus.memInst <= '0;
      issued <= '0;
      rcv <= '0;
      pending <= 1'b0;
    end else if (rdy) begin
      bus.memInstOutEn <= fill;
      case (state)
        IDLE: if (bus.instEn & ~line_hit & ~bus.misTaken) begin
          state <= REFILL;
          req_word <= bus.instAddr[ADDR_W-1:2];
          bus.ramReq <= 1'b1;
          issued <= '0;
          rcv <= '0;
          pending <= 1'b0;
        end
        REFILL: if (bus.misTaken) begin
          state <= IDLE;
          bus.ramReq <= 1'b0;
          pending <= 1'b0;
        end else begin
          pending <= grant;
          if (grant) begin
            issued <= issued + 3'd1;
            bus.ramReq <= issued != 3'd3;
          end
          if (pending) begin
            word <= {bus.ramData, word[23:8]};
            rcv <= rcv + 2'd1;
          end
          if (fill) begin
            state <= DONE;
            bus.memInst <= fill_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed + randomized check of inst_cache against a transaction-level cache/refill model
module tb_inst_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;
  inst_cache_if bus();
  inst_cache dut(.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  int phase = 0;
  logic [29:0] raddr = '0;
  int n_iss = 0;
  int n_rcv = 0;
  bit inflight = 0;
  logic [1:0] inflight_k = '0;
  logic [31:0] exp_inst = '0;
  bit known = 0;
  logic [29:0] lines [int];
  int cyc_n = 0;
  int pulse_cyc = -1;
  int pulses = 0;
  logic last_hit, last_req, last_oen;
  logic [31:0] last_cinst, last_raddr, last_inst;

  function automatic logic [7:0] mem_byte(logic [31:0] a);
    if (a[31:2] == 30'd0)
      case (a[1:0])
        2'd0: return 8'h13;
        2'd1: return 8'h05;
        2'd2: return 8'h50;
        default: return 8'h00;
      endcase
    return (a[9:2] * 8'd37) ^ a[17:10] ^ {a[1:0], a[5:0]} ^ 8'h5a;
  endfunction

  function automatic logic [31:0] mem_word(logic [29:0] w);
    return {mem_byte({w, 2'd3}), mem_byte({w, 2'd2}), mem_byte({w, 2'd1}), mem_byte({w, 2'd0})};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic cyc(bit r, bit rd, bit en, logic [31:0] a, bit mis, bit g);
    bit e_hit, e_req, grant;
    int idx;
    @(negedge clk);
    rst = r;
    rdy = rd;
    bus.instEn = en;
    bus.instAddr = a;
    bus.misTaken = mis;
    bus.ramGnt = g;
    bus.ramData = inflight ? mem_byte({raddr, inflight_k}) : 8'($urandom);
    #1;
    idx = int'(a[8:2]);
    e_hit = en && lines.exists(idx) && lines[idx] == a[31:2];
    e_req = phase == 1 && n_iss < 4;
    grant = e_req && g;
    last_hit = bus.hit;
    last_req = bus.ramReq;
    last_oen = bus.memInstOutEn;
    last_cinst = bus.cacheInst;
    last_raddr = bus.ramAddr;
    last_inst = bus.memInst;
    if (bus.memInstOutEn === 1'b1) begin
      pulses++;
      pulse_cyc = cyc_n;
    end
    if (known) begin
      chk("hit", {31'd0, bus.hit}, {31'd0, e_hit});
      if (e_hit) chk("cacheInst", bus.cacheInst, mem_word(a[31:2]));
      chk("ramReq", {31'd0, bus.ramReq}, {31'd0, e_req});
      if (e_req) chk("ramAddr", bus.ramAddr, {raddr, 2'(n_iss)});
      chk("memInstOutEn", {31'd0, bus.memInstOutEn}, {31'd0, phase == 2});
      chk("memInst", bus.memInst, exp_inst);
    end
    if (!r) begin
      phase = 0;
      lines.delete();
      exp_inst = '0;
      inflight = 0;
      known = 1;
    end else if (rd) begin
      case (phase)
        0: if (en && !e_hit && !mis) begin
          phase = 1;
          raddr = a[31:2];
          n_iss = 0;
          n_rcv = 0;
        end
        1: if (mis) phase = 0;
        else begin
          if (inflight) n_rcv++;
          if (n_rcv == 4) begin
            phase = 2;
            exp_inst = mem_word(raddr);
            lines[int'(raddr[6:0])] = raddr;
          end
          if (grant) begin
            inflight_k = 2'(n_iss);
            n_iss++;
          end
        end
        default: phase = 0;
      endcase
      inflight = phase == 1 && grant;
    end
    cyc_n++;
  endtask

  task automatic finish_refill();
    for (int i = 0; i < 40 && phase != 0; i++) cyc(1, 1, 0, 32'h0, 0, 1);
    if (phase != 0) begin
      miscompares++;
      $display("FAIL refill_timeout: refill still busy after 40 cycles, expected idle");
    end
  endtask

  initial begin
    int s, p0;
    bus.instEn = 0;
    bus.instAddr = '0;
    bus.misTaken = 0;
    bus.ramGnt = 0;
    bus.ramData = '0;
    cyc(0, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    cyc(1, 1, 0, 32'h0, 0, 0);
    chk("reset_ramReq", {31'd0, last_req}, 32'd0);
    chk("reset_pulse", {31'd0, last_oen}, 32'd0);
    chk("reset_memInst", last_inst, 32'd0);
    // basic miss with continuous grant
    cyc(1, 1, 1, 32'h0, 0, 1);
    chk("t1_miss", {31'd0, last_hit}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 32'h0, 0, 1);
      chk("t1_req", {31'd0, last_req}, 32'd1);
      chk("t1_addr", last_raddr, k);
    end
    cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t1_t5_pulse", {31'd0, last_oen}, 32'd0);
    chk("t1_t5_req", {31'd0, last_req}, 32'd0);
    cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t1_t6_pulse", {31'd0, last_oen}, 32'd1);
    chk("t1_word", last_inst, 32'h00500513);
    cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t1_t7_pulse", {31'd0, last_oen}, 32'd0);
    // hit on the filled line
    cyc(1, 1, 1, 32'h0, 0, 0);
    chk("t2_hit", {31'd0, last_hit}, 32'd1);
    chk("t2_inst", last_cinst, 32'h00500513);
    chk("t2_req", {31'd0, last_req}, 32'd0);
    cyc(1, 1, 0, 32'h0, 0, 0);
    chk("t2_req_after", {31'd0, last_req}, 32'd0);
    // grant gap of three cycles after byte 1
    s = cyc_n;
    pulse_cyc = -1;
    cyc(1, 1, 1, 32'h40, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 32'h0, 0, 0);
    for (int k = 0; k < 20 && !last_oen; k++) cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t3_latency", pulse_cyc - s, 32'd9);
    chk("t3_word", last_inst, mem_word(30'h10));
    finish_refill();
    // mispredict abort then a new miss
    p0 = pulses;
    cyc(1, 1, 1, 32'h100, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    cyc(1, 1, 0, 32'h0, 1, 1);
    cyc(1, 1, 1, 32'h200, 0, 1);
    chk("t4_req_dropped", {31'd0, last_req}, 32'd0);
    cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t4_new_req", {31'd0, last_req}, 32'd1);
    chk("t4_new_addr", last_raddr, 32'h200);
    chk("t4_no_pulse", pulses - p0, 32'd0);
    for (int k = 0; k < 20 && !last_oen; k++) cyc(1, 1, 0, 32'h0, 0, 1);
    chk("t4_word", last_inst, mem_word(30'h80));
    finish_refill();
    cyc(1, 1, 1, 32'h100, 0, 1);
    chk("t4_aborted_misses", {31'd0, last_hit}, 32'd0);
    finish_refill();
    // same-index conflict
    cyc(1, 1, 1, 32'h0, 0, 1);
    finish_refill();
    cyc(1, 1, 1, 32'h0, 0, 1);
    chk("t5_hit0", {31'd0, last_hit}, 32'd1);
    cyc(1, 1, 1, 32'h200, 0, 1);
    chk("t5_miss200", {31'd0, last_hit}, 32'd0);
    finish_refill();
    cyc(1, 1, 1, 32'h200, 0, 1);
    chk("t5_hit200", {31'd0, last_hit}, 32'd1);
    chk("t5_inst200", last_cinst, mem_word(30'h80));
    cyc(1, 1, 1, 32'h0, 0, 1);
    chk("t5_evicted0", {31'd0, last_hit}, 32'd0);
    finish_refill();
    // reset in the middle of a refill
    cyc(1, 1, 1, 32'h300, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    cyc(1, 1, 0, 32'h0, 0, 1);
    cyc(0, 1, 0, 32'h0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 32'h0, 0, 1);
      chk("t6_req", {31'd0, last_req}, 32'd0);
      chk("t6_pulse", {31'd0, last_oen}, 32'd0);
    end
    cyc(1, 1, 1, 32'h0, 0, 1);
    chk("t6_cleared", {31'd0, last_hit}, 32'd0);
    finish_refill();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      bit r, rd;
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      r = ($urandom % 200) != 0;
      rd = inflight ? 1'b1 : (($urandom % 6) != 0);
      cyc(r, rd, ($urandom % 3) == 0, a, ($urandom % 25) == 0, ($urandom % 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Responder side of the fetch stage's instruction-request interface.
- Accepts a one-cycle instruction request (instEn/instAddr) and answers a valid hit in the same cycle (hit/cacheInst).
- On a miss, refills the word through the byte-serial RAM port, returns it with a one-cycle memInstOutEn pulse, and installs it in a direct-mapped array.
- Sits between fetch and the memory arbiter; honours branch-mispredict aborts (misTaken).

Parameters:
INDEX_BITS, 7, line index width; 2^INDEX_BITS one-word lines; index = instAddr[INDEX_BITS+1:2], tag = instAddr[31:INDEX_BITS+2]
ADDR_W, 32, instruction address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset (0 = reset)
rdy  in  1  global ready; when 0, no state changes
instEn  in  1  fetch request, one-cycle pulse
instAddr  in  32  request address, word aligned; bits [1:0] ignored
misTaken  in  1  mispredict; abort any pending refill
hit  out  1  combinational: instEn & valid[idx] & tag match
cacheInst  out  32  combinational line data for instAddr
memInstOutEn  out  1  registered one-cycle refill-complete pulse
memInst  out  32  registered refilled word; holds until next refill completes
ramReq  out  1  byte read request to arbiter
ramAddr  out  32  byte address {reqAddr[31:2], k}, k = 0..3
ramGnt  in  1  arbiter accepted ramReq/ramAddr this cycle
ramData  in  8  byte for a grant in the previous cycle

Behaviour:
- Reset (rst=0 at an edge):
  - state <= IDLE; all valid bits cleared.
  - memInstOutEn, ramReq <= 0; memInst <= 0; issue and receive counters <= 0.
  - Tag and data arrays are not reset.
  - Reset mid-refill abandons it; no pulse and no fill.
- rdy=0: every register holds, including counters and the pending-byte flag. The arbiter never returns data while rdy=0.
- States:
  - IDLE: if instEn & ~hit & ~misTaken, latch reqAddr and go to REFILL. Requests with hit=1 need no action.
  - REFILL: ramReq=1 while issued<4, with ramAddr byte = issued. Each ramReq&ramGnt increments issued and sets the pending flag. A byte arriving for the previous-cycle grant goes into word[8*rcv +: 8] (little-endian) and increments rcv. When the 4th byte is captured, go to DONE.
  - DONE (one cycle): memInstOutEn=1 and memInst=assembled word. On the entry edge, write the line (valid, tag, data). Next state IDLE.
- Latency with continuous grant:
  - Miss request in cycle t.
  - Byte 0 issued in t+1, byte 3 in t+4, bytes returned t+2..t+5.
  - memInstOutEn high in t+6 only.
  - Each ungranted cycle adds one cycle.
- misTaken (any state except IDLE):
  - Go to IDLE next edge; ramReq=0 from the next cycle.
  - The byte of a grant already in flight is discarded; no fill, no memInstOutEn.
  - misTaken in DONE: the pulse still occurs, because the line is correct and is filled; fetch ignores it.
  - An instEn coincident with misTaken is ignored.
- instEn while REFILL/DONE is protocol-illegal (fetch waits for the response) and is ignored.
- Hit uses array contents as of the current cycle. A line written at the DONE edge hits from t+6 onward.
- Conflict: a same-index, different-tag miss overwrites the line.

Decomposition:
- Shared defines file:
  - Existing InstAddrBus, InstBus, Enable/Disable, addrFree, dataFree.
  - New ICacheIndexBits, ICacheTagBus, RamDataBus macros.
- One natural sub-module, icache_store:
  - Holds the valid vector, tag array and data array.
  - Combinational read port and single synchronous write port; valid-clear on reset.
- inst_cache keeps the FSM, counters, word assembly and RAM handshake.

Test Plan:
1. After reset, instEn addr 0x00000000 in cycle t, ramGnt=1 always, bytes 0x13,0x05,0x50,0x00 -> hit=0; ramAddr 0x0..0x3 in t+1..t+4; memInstOutEn=1 only in t+6; memInst=0x00500513.
2. Then instEn addr 0x00000000 -> hit=1 same cycle, cacheInst=0x00500513, ramReq stays 0.
3. Miss at 0x00000040 with ramGnt=0 for 3 cycles after byte 1 -> memInstOutEn in t+9, word assembled correctly, no duplicate byte addresses.
4. Miss at 0x00000100, misTaken in t+3, then instEn 0x00000200 in t+4 -> no pulse for 0x100, ramReq=0 in t+4, 0x200 refill starts t+5, 0x100 still misses later.
5. Fill 0x00000000, then miss at 0x00000200 (same index, INDEX_BITS=7) -> 0x200 is filled; subsequent 0x0 misses again.
6. rst=0 during t+3 of a refill -> ramReq=0 and memInstOutEn=0 afterwards; previously filled 0x0 now misses.
